// File: rtl/weight_quantizer_pkg.sv
// Shared quantization definitions: FSM encoding, int8 saturation limits and
// the largest block scale exponent, common to weight and activation paths.
package weight_quantizer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCALE,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic signed [7:0] Q_MAX     = 8'sh7f;
    localparam logic signed [7:0] Q_MIN     = 8'sh80;
    localparam int                MAX_SHIFT = 25;

endpackage

// File: rtl/round_sat8.sv
// Round-half-up arithmetic right shift of a 34-bit signed value, then
// saturation to the signed 8-bit range.
module round_sat8
    import weight_quantizer_pkg::*;
#(
    parameter int SHIFT_W = 5
) (
    input  logic [33:0]        x,
    input  logic [SHIFT_W-1:0] s,
    output logic [7:0]         q
);

    localparam logic signed [33:0] LIM_HI = 34'(Q_MAX);
    localparam logic signed [33:0] LIM_LO = 34'(Q_MIN);

    logic signed [33:0] rnd;
    logic signed [33:0] sum;
    logic signed [33:0] shifted;

    function automatic logic [7:0] sat8(input logic signed [33:0] v);
        if (v > LIM_HI) return Q_MAX;
        if (v < LIM_LO) return Q_MIN;
        return v[7:0];
    endfunction

    always_comb begin
        rnd = '0;
        if (s != '0) rnd = 34'sd1 <<< (s - SHIFT_W'(1));
        sum     = $signed(x) + rnd;
        shifted = sum >>> s;
        q       = sat8(shifted);
    end

endmodule

// File: rtl/weight_quantizer.sv
// Block weight quantizer: buffers DEPTH int32 weights, picks a shared
// power-of-two scale from the block max magnitude, then streams int8 weights.
module weight_quantizer
    import weight_quantizer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int SHIFT_W = 5
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic [31:0]        din_i,
    input  logic               din_valid_i,
    output logic               busy_o,
    output logic [7:0]         qout_o,
    output logic               qvalid_o,
    output logic [SHIFT_W-1:0] shift_o,
    output logic               done_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(DEPTH - 1);
    localparam logic [IDX_W:0] END_IDX  = (IDX_W+1)'(DEPTH);

    state_t             state, state_nxt;
    logic [IDX_W:0]     wr_idx, rd_idx;
    logic [32:0]        max_abs, din_ext, din_mag;
    logic [31:0]        mem [DEPTH];
    logic [IDX_W-1:0]   rd_sel;
    logic [31:0]        rd_word;
    logic [SHIFT_W-1:0] shift_calc, shift_sel;
    logic [7:0]         q_round;
    logic               load_acc, emit_more;

    assign load_acc  = (state == ST_LOAD) && din_valid_i;
    assign emit_more = (state == ST_EMIT) && (rd_idx != END_IDX);

    // 33-bit magnitude so that -2^31 maps to +2^31
    always_comb begin
        din_ext = {din_i[31], din_i};
        din_mag = din_i[31] ? (~din_ext + 33'd1) : din_ext;
    end

    always_comb begin
        shift_calc = SHIFT_W'(MAX_SHIFT);
        for (int i = MAX_SHIFT - 1; i >= 0; i--) begin
            if ((max_abs >> i) <= 33'd127) shift_calc = SHIFT_W'(i);
        end
    end

    // SCALE emits sample 0 with the freshly computed shift so EMIT starts registered
    always_comb begin
        rd_sel    = (state == ST_SCALE) ? '0 : rd_idx[IDX_W-1:0];
        rd_word   = mem[rd_sel];
        shift_sel = (state == ST_SCALE) ? shift_calc : shift_o;
    end

    round_sat8 #(.SHIFT_W(SHIFT_W)) u_round (
        .x (({{2{rd_word[31]}}, rd_word})),
        .s (shift_sel),
        .q (q_round)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i) state_nxt = ST_LOAD;
            ST_LOAD:  if (load_acc && (wr_idx == LAST_IDX)) state_nxt = ST_SCALE;
            ST_SCALE: state_nxt = ST_EMIT;
            ST_EMIT:  if (rd_idx == END_IDX) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= ST_IDLE;
            wr_idx   <= '0;
            rd_idx   <= '0;
            max_abs  <= '0;
            shift_o  <= '0;
            qout_o   <= '0;
            qvalid_o <= 1'b0;
            done_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt != ST_IDLE);
            done_o <= (state == ST_EMIT) && (rd_idx == END_IDX);
            if (state == ST_IDLE && start_i) begin
                wr_idx  <= '0;
                max_abs <= '0;
            end
            if (load_acc) begin
                wr_idx <= wr_idx + 1'b1;
                if (din_mag > max_abs) max_abs <= din_mag;
            end
            if (state == ST_SCALE) begin
                shift_o <= shift_calc;
                rd_idx  <= (IDX_W+1)'(1);
            end
            if (emit_more) rd_idx <= rd_idx + 1'b1;
            qvalid_o <= (state == ST_SCALE) || emit_more;
            qout_o   <= ((state == ST_SCALE) || emit_more) ? q_round : 8'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_acc) mem[wr_idx[IDX_W-1:0]] <= din_i;
    end

endmodule

// File: tb/tb_weight_quantizer.sv
// Directed bench for weight_quantizer: stimulus pushes hand-computed int8
// results into a queue that a negedge monitor pops whenever qvalid_o is high.
module tb_weight_quantizer;

    localparam int DEPTH   = 16;
    localparam int SHIFT_W = 5;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        din = '0;
    logic               din_valid = 1'b0;
    logic               busy;
    logic [7:0]         qout;
    logic               qvalid;
    logic [SHIFT_W-1:0] shift;
    logic               done;

    weight_quantizer #(.DEPTH(DEPTH), .SHIFT_W(SHIFT_W)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start),
        .din_i       (din),
        .din_valid_i (din_valid),
        .busy_o      (busy),
        .qout_o      (qout),
        .qvalid_o    (qvalid),
        .shift_o     (shift),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int q;
        int s;
    } exp_t;
    exp_t exp_q[$];

    int smp  [DEPTH];
    int expq [DEPTH];

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every valid output is matched against the next queued expectation
    always @(negedge clk) begin
        if (rstn) begin
            if (qvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_qvalid", int'(qvalid), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("qout", int'($signed(qout)), e.q);
                    check("shift", int'(shift), e.s);
                end
            end else begin
                check("qout_zero_when_invalid", int'($signed(qout)), 0);
            end
        end
    end

    task automatic run_block(input int exp_s, input bit gaps, input bit poke_start);
        int  k;
        bit  got;
        for (int i = 0; i < DEPTH; i++) begin
            exp_t e;
            e.q = expq[i];
            e.s = exp_s;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps && (i % 2 == 1)) begin
                din_valid = 1'b0;
                din = 32'hdead_beef;
                @(negedge clk);
            end
            din = smp[i];
            din_valid = 1'b1;
            k = cyc;
            @(negedge clk);
        end
        din_valid = 1'b0;
        din = '0;
        got = 1'b0;
        for (int j = 0; j < 60; j++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (poke_start && j == 3) begin
                start = 1'b1;
                din_valid = 1'b1;
                din = 32'd7777;
            end else begin
                start = 1'b0;
                din_valid = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        din_valid = 1'b0;
        if (got) check("done_latency", cyc, k + 2 + DEPTH);
        else     check("done_timeout", int'(got), 1);
        check("outputs_before_done", exp_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        if (poke_start) begin
            repeat (30) @(negedge clk);
            check("no_extra_block_busy", int'(busy), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_qout", int'(qout), 0);
        check("rst_qvalid", int'(qvalid), 0);
        check("rst_shift", int'(shift), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        rstn = 1'b1;
        @(negedge clk);

        // all 100 -> shift 0, unchanged
        for (int i = 0; i < DEPTH; i++) begin smp[i] = 100; expq[i] = 100; end
        run_block(0, 1'b0, 1'b0);

        // max 1000 -> shift 3: 1004>>3=125, -996>>3=-125, 16>>3=2
        for (int i = 0; i < DEPTH; i++) begin smp[i] = 0; expq[i] = 0; end
        smp[0] = 1000;  expq[0] = 125;
        smp[1] = -1000; expq[1] = -125;
        smp[2] = 12;    expq[2] = 2;
        run_block(3, 1'b0, 1'b0);

        // max 255 -> shift 1: 256>>1 saturates, -254>>1=-127, 4>>1=2, -2>>1=-1
        for (int i = 0; i < DEPTH; i++) begin smp[i] = 0; expq[i] = 0; end
        smp[0] = 255;  expq[0] = 127;
        smp[1] = -255; expq[1] = -127;
        smp[2] = 3;    expq[2] = 2;
        smp[3] = -3;   expq[3] = -1;
        run_block(1, 1'b0, 1'b0);

        // -2^31 -> shift 25: (-2^31+2^24)>>25=-64, (-2^31+2^25)>>25=-63
        for (int i = 0; i < DEPTH; i++) begin smp[i] = 0; expq[i] = 0; end
        smp[0] = 32'sh8000_0000; expq[0] = -64;
        smp[1] = 32'sh8100_0000; expq[1] = -63;
        run_block(25, 1'b0, 1'b0);

        // partial block of large values, then asynchronous reset
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            din = 32'd20000;
            din_valid = 1'b1;
            @(negedge clk);
        end
        din_valid = 1'b0;
        check("busy_loading", int'(busy), 1);
        #2 rstn = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_shift", int'(shift), 0);
        check("midrst_qvalid", int'(qvalid), 0);
        check("midrst_qout", int'(qout), 0);
        check("midrst_done", int'(done), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // fresh block: max 500 -> shift 2: 502>>2=125, -498>>2=-125
        for (int i = 0; i < DEPTH; i++) begin
            smp[i]  = (i % 2 == 0) ? 500 : -500;
            expq[i] = (i % 2 == 0) ? 125 : -125;
        end
        run_block(2, 1'b0, 1'b0);

        // valid gaps plus start/din pulses during EMIT: max 80 -> shift 0
        for (int i = 0; i < DEPTH; i++) begin
            smp[i]  = i * 10 - 70;
            expq[i] = i * 10 - 70;
        end
        run_block(0, 1'b1, 1'b1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
